// File: rtl/axis_uart_framer.sv
// axis_uart_framer: adds tlast framing (delimiter, max length, idle timeout) to a received
// character stream; one character is held back so tlast lands on the true final beat.
module axis_uart_framer #(
    parameter int          WORD_SIZE    = 8,
    parameter logic [15:0] DELIM        = 16'h000A,
    parameter bit          USE_DELIM    = 1'b1,
    parameter int          MAX_LEN      = 256,
    parameter int          IDLE_TIMEOUT = 1000
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [WORD_SIZE-1:0] s_axis_tdata,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [WORD_SIZE-1:0] m_axis_tdata,
    output logic [1:0]           m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 frame_timeout
);
    localparam int BW = $clog2(MAX_LEN + 1);
    localparam int IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    logic                 hold_valid_q, hold_valid_d, hold_perr_q, hold_perr_d;
    logic                 hold_ferr_q, hold_ferr_d, hold_last_q, hold_last_d;
    logic [WORD_SIZE-1:0] hold_data_q, hold_data_d, out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [1:0]           out_user_q, out_user_d;
    logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic                 err_acc_q, err_acc_d, timeout_q, timeout_d;
    logic                 out_free, in_hs, in_last, in_ferr, xfer, fire;

    always_comb begin
        out_free = !out_valid_q | m_axis_tready;
        in_hs    = s_axis_tvalid & (!hold_valid_q | out_free);
        in_last  = (USE_DELIM && s_axis_tdata == DELIM[WORD_SIZE-1:0]) || beat_cnt_q == BW'(MAX_LEN - 1);
        in_ferr  = err_acc_q | s_axis_tuser;
        // a non-last character only leaves once its successor is being accepted
        xfer     = out_free & hold_valid_q & (hold_last_q | in_hs);
        fire     = IDLE_TIMEOUT > 0 && hold_valid_q && !hold_last_q && !in_hs &&
                   idle_cnt_q == IW'(IDLE_TIMEOUT - 1);
        hold_valid_d = in_hs | (hold_valid_q & !xfer);
        hold_data_d  = in_hs ? s_axis_tdata : hold_data_q;
        hold_perr_d  = in_hs ? s_axis_tuser : hold_perr_q;
        hold_ferr_d  = in_hs ? in_ferr : hold_ferr_q;
        hold_last_d  = in_hs ? in_last : (hold_last_q | fire);
        beat_cnt_d   = (in_hs & !in_last) ? beat_cnt_q + 1'b1 : (in_hs | fire) ? '0 : beat_cnt_q;
        err_acc_d    = (in_hs & !in_last) ? in_ferr : (in_hs | fire) ? 1'b0 : err_acc_q;
        idle_cnt_d   = (in_hs | fire) ? '0 :
                       (IDLE_TIMEOUT > 0 && hold_valid_q && !hold_last_q) ? idle_cnt_q + 1'b1 : idle_cnt_q;
        out_valid_d  = xfer | (out_valid_q & !out_free);
        out_data_d   = xfer ? hold_data_q : out_data_q;
        out_user_d   = xfer ? {hold_last_q & hold_ferr_q, hold_perr_q} : out_user_q;
        out_last_d   = xfer ? hold_last_q : out_last_q;
        timeout_d    = fire;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_perr_q  <= 1'b0;
            hold_ferr_q  <= 1'b0;
            hold_last_q  <= 1'b0;
            beat_cnt_q   <= '0;
            err_acc_q    <= 1'b0;
            idle_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_user_q   <= '0;
            out_last_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_perr_q  <= hold_perr_d;
            hold_ferr_q  <= hold_ferr_d;
            hold_last_q  <= hold_last_d;
            beat_cnt_q   <= beat_cnt_d;
            err_acc_q    <= err_acc_d;
            idle_cnt_q   <= idle_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_user_q   <= out_user_d;
            out_last_q   <= out_last_d;
            timeout_q    <= timeout_d;
        end
    end

    assign s_axis_tready = !hold_valid_q | out_free;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tuser  = out_user_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tvalid = out_valid_q;
    assign frame_timeout = timeout_q;
endmodule

// File: tb/tb_axis_uart_framer.sv
// tb_axis_uart_framer: directed checks of framing, timeout, parity flags, backpressure and reset.
module tb_axis_uart_framer;
    typedef struct packed {
        logic [7:0] d;
        logic [1:0] u;
        logic       l;
    } beat_t;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tuser = 1'b0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic [1:0] m_axis_tuser;
    logic       m_axis_tlast;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic       frame_timeout;

    int    n_chk = 0, n_fail = 0, to_cnt = 0, stab_bad = 0, zeros = 0, mcnt = 0;
    bit    bp_en = 1'b0, tready_fix = 1'b1, stalled = 1'b0;
    logic  macc = 1'b0;
    logic [11:0] prev = '0;
    beat_t got[$], exp[$];

    axis_uart_framer #(.WORD_SIZE(8), .DELIM(16'h000A), .USE_DELIM(1'b1), .MAX_LEN(4), .IDLE_TIMEOUT(20)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .frame_timeout(frame_timeout)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        #1;
        if (bp_en) begin
            m_axis_tready = zeros >= 6 || $urandom_range(0, 9) < 3;
            zeros = m_axis_tready ? 0 : zeros + 1;
        end else m_axis_tready = tready_fix;
    end

    always @(negedge aclk) begin
        if (!aresetn) stalled = 1'b0;
        else begin
            if (stalled && {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast} != prev) stab_bad++;
            if (m_axis_tvalid && m_axis_tready) got.push_back('{d: m_axis_tdata, u: m_axis_tuser, l: m_axis_tlast});
            if (frame_timeout) to_cnt++;
            stalled = m_axis_tvalid && !m_axis_tready;
            prev = {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic u);
        int n = 0;
        s_axis_tdata = d;
        s_axis_tuser = u;
        s_axis_tvalid = 1'b1;
        do begin
            @(negedge aclk);
            n++;
        end while (!s_axis_tready && n < 200);
        if (!s_axis_tready) check("send_ready", 32'(s_axis_tready), 32'd1);
        @(posedge aclk);
        #2;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic want(input logic [7:0] d, input logic [1:0] u, input logic l);
        exp.push_back('{d: d, u: u, l: l});
    endtask

    task automatic model(input logic [7:0] d, input logic u);
        logic l, f;
        l = d == 8'h0A || mcnt == 3;
        f = macc | u;
        want(d, {l & f, u}, l);
        if (l) begin
            mcnt = 0;
            macc = 1'b0;
        end else begin
            mcnt++;
            macc = f;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (got.size() < exp.size() && n < budget) begin
            tick(1);
            n++;
        end
        tick(3);
    endtask

    task automatic check_q(input string tag);
        check({tag, "_n"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s_d%0d", tag, i), 32'(got[i].d), 32'(exp[i].d));
            check($sformatf("%s_u%0d", tag, i), 32'(got[i].u), 32'(exp[i].u));
            check($sformatf("%s_l%0d", tag, i), 32'(got[i].l), 32'(exp[i].l));
        end
        got.delete();
        exp.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n;
        logic [7:0] d;
        logic u;
        tick(3);
        check("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_sready", 32'(s_axis_tready), 32'd1);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tuser", 32'(m_axis_tuser), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_timeout", 32'(frame_timeout), 32'd0);
        aresetn = 1'b1;
        tick(2);

        // delimiter framing
        send(8'h48, 1'b0); send(8'h69, 1'b0); send(8'h0A, 1'b0);
        want(8'h48, 2'b00, 1'b0); want(8'h69, 2'b00, 1'b0); want(8'h0A, 2'b00, 1'b1);
        drain(50);
        check_q("delim");

        // parity flag, then a clean frame
        send(8'h61, 1'b0); send(8'h62, 1'b1); send(8'h0A, 1'b0);
        send(8'h63, 1'b0); send(8'h0A, 1'b0);
        want(8'h61, 2'b00, 1'b0); want(8'h62, 2'b01, 1'b0); want(8'h0A, 2'b10, 1'b1);
        want(8'h63, 2'b00, 1'b0); want(8'h0A, 2'b00, 1'b1);
        drain(50);
        check_q("perr");

        // max length 4 with gaps, tail closed by timeout
        t0 = to_cnt;
        for (int i = 0; i < 10; i++) begin
            send(8'h30 + 8'(i), 1'b0);
            want(8'h30 + 8'(i), 2'b00, i == 3 || i == 7 || i == 9);
            tick(3);
        end
        drain(100);
        check_q("maxlen");
        check("maxlen_to", 32'(to_cnt - t0), 32'd1);

        // idle timeout latency
        t0 = to_cnt;
        send(8'h41, 1'b0);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!m_axis_tvalid && n < 60);
        check("to_lat", 32'(n), 32'd21);
        check("to_data", 32'(m_axis_tdata), 32'h41);
        check("to_last", 32'(m_axis_tlast), 32'd1);
        check("to_user", 32'(m_axis_tuser), 32'd0);
        check("to_pulse", 32'(to_cnt - t0), 32'd1);
        tick(3);
        got.delete();

        // successor arrives in the very cycle the timeout would fire
        t0 = to_cnt;
        send(8'h42, 1'b0);
        tick(19);
        send(8'h43, 1'b0);
        send(8'h0A, 1'b0);
        want(8'h42, 2'b00, 1'b0); want(8'h43, 2'b00, 1'b0); want(8'h0A, 2'b00, 1'b1);
        drain(60);
        check_q("race");
        check("race_to", 32'(to_cnt - t0), 32'd0);

        // random backpressure with a framing/parity model
        t0 = to_cnt;
        stab_bad = 0;
        mcnt = 0;
        macc = 1'b0;
        bp_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            d = 8'($urandom_range(0, 255));
            u = $urandom_range(0, 7) == 0;
            model(d, u);
            send(d, u);
        end
        model(8'h0A, 1'b0);
        send(8'h0A, 1'b0);
        drain(2000);
        bp_en = 1'b0;
        tick(2);
        check_q("bp");
        check("bp_stable", 32'(stab_bad), 32'd0);
        check("bp_to", 32'(to_cnt - t0), 32'd0);

        // reset with a character held and one stalled on the output
        tready_fix = 1'b0;
        tick(2);
        send(8'h78, 1'b0);
        send(8'h79, 1'b0);
        check("pre_rst_mvalid", 32'(m_axis_tvalid), 32'd1);
        aresetn = 1'b0;
        tick(1);
        check("mid_rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_sready", 32'(s_axis_tready), 32'd1);
        check("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
        aresetn = 1'b1;
        tready_fix = 1'b1;
        tick(2);
        got.delete();
        for (int i = 0; i < 4; i++) begin
            send(8'h51 + 8'(i), 1'b0);
            want(8'h51 + 8'(i), 2'b00, i == 3);
        end
        drain(50);
        check_q("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
